// File: rtl/traffic_pkg.sv
// Shared types and light encodings for the intersection phase controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_G    = 3'd0,
        MAIN_Y    = 3'd1,
        RED_A     = 3'd2,
        SIDE_G    = 3'd3,
        SIDE_Y    = 3'd4,
        PED_WALK  = 3'd5,
        PED_FLASH = 3'd6,
        RED_B     = 3'd7
    } phase_e;

    localparam logic [2:0] RED       = 3'b100;
    localparam logic [2:0] YELLOW    = 3'b010;
    localparam logic [2:0] GREEN     = 3'b001;

    localparam logic [1:0] WALK      = 2'b10;
    localparam logic [1:0] DONT_WALK = 2'b01;
    localparam logic [1:0] DARK      = 2'b00;

    // Main-road lamp shown in a given phase
    function automatic logic [2:0] main_light_of(input phase_e s);
        case (s)
            MAIN_G:  return GREEN;
            MAIN_Y:  return YELLOW;
            default: return RED;
        endcase
    endfunction

    // Side-road lamp shown in a given phase
    function automatic logic [2:0] side_light_of(input phase_e s);
        case (s)
            SIDE_G:  return GREEN;
            SIDE_Y:  return YELLOW;
            default: return RED;
        endcase
    endfunction

    // Pedestrian lamp; dark only applies during the flashing phase
    function automatic logic [1:0] ped_light_of(input phase_e s, input logic dark);
        case (s)
            PED_WALK:  return WALK;
            PED_FLASH: return dark ? DARK : DONT_WALK;
            default:   return DONT_WALK;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable seconds down-counter; done fires on the tick that finds it at zero.
module phase_timer #(
    parameter int unsigned    CNT_W   = 5,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done_c
);

    logic [CNT_W-1:0] r_cnt;

    // Reload on phase entry, otherwise count ticks down to zero and hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done_c = i_tick && (r_cnt == '0);

endmodule

// File: rtl/intersection_phase_ctrl.sv
// Two-road intersection controller with one pedestrian crossing.
// Optional build macro PED_COUNTDOWN_EN adds the ped_remain crossing countdown.
module intersection_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned T_MAIN_MIN = 10,
    parameter int unsigned T_YELLOW   = 3,
    parameter int unsigned T_ALL_RED  = 1,
    parameter int unsigned T_SIDE_G   = 8,
    parameter int unsigned T_WALK     = 7,
    parameter int unsigned T_FLASH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             ped_btn,
    input  logic             side_sensor,
    output logic [2:0]       main_light,
    output logic [2:0]       side_light,
    output logic [1:0]       ped_light,
    output logic             ped_wait,
    output logic [2:0]       phase
`ifdef PED_COUNTDOWN_EN
    ,
    output logic [CNT_W-1:0] ped_remain
`endif
);

    phase_e           r_state;
    phase_e           w_next;
    logic             r_ped_req;
    logic             r_side_req;
    logic             r_rr_last;
    logic             r_flash_dark;
    logic [CNT_W-1:0] r_elapsed;
    logic [2:0]       r_main_light;
    logic [2:0]       r_side_light;
    logic [1:0]       r_ped_light;
    logic             w_enter;
    logic             w_done;
    logic             w_next_dark;
    logic             w_min_green;
    logic [CNT_W-1:0] w_load_val;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(T_ALL_RED - 1))
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_tick     (tick_1hz),
        .i_load     (w_enter),
        .i_load_val (w_load_val),
        .o_done_c   (w_done)
    );

    // The current tick completes the minimum green once elapsed reaches T_MAIN_MIN-1
    assign w_min_green = (r_elapsed >= CNT_W'(T_MAIN_MIN - 1));

    // Phase sequencing and the round-robin grant at the end of RED_A
    always_comb begin
        w_next = r_state;
        case (r_state)
            MAIN_G:    if (tick_1hz && w_min_green && (r_ped_req || r_side_req)) w_next = MAIN_Y;
            MAIN_Y:    if (w_done) w_next = RED_A;
            RED_A: begin
                if (w_done) begin
                    if (r_ped_req && r_side_req) w_next = r_rr_last ? SIDE_G : PED_WALK;
                    else if (r_side_req)         w_next = SIDE_G;
                    else if (r_ped_req)          w_next = PED_WALK;
                    else                         w_next = MAIN_G;
                end
            end
            SIDE_G:    if (w_done) w_next = SIDE_Y;
            SIDE_Y:    if (w_done) w_next = RED_B;
            PED_WALK:  if (w_done) w_next = PED_FLASH;
            PED_FLASH: if (w_done) w_next = RED_B;
            RED_B:     if (w_done) w_next = MAIN_G;
        endcase
    end

    assign w_enter = (w_next != r_state);

    // Timer reload value for the phase being entered
    always_comb begin
        w_load_val = CNT_W'(T_MAIN_MIN - 1);
        case (w_next)
            MAIN_Y, SIDE_Y: w_load_val = CNT_W'(T_YELLOW - 1);
            RED_A, RED_B:   w_load_val = CNT_W'(T_ALL_RED - 1);
            SIDE_G:         w_load_val = CNT_W'(T_SIDE_G - 1);
            PED_WALK:       w_load_val = CNT_W'(T_WALK - 1);
            PED_FLASH:      w_load_val = CNT_W'(T_FLASH - 1);
            default:        w_load_val = CNT_W'(T_MAIN_MIN - 1);
        endcase
    end

    // Flash phase restarts at DONT_WALK on any entry and toggles per tick
    assign w_next_dark = w_enter ? 1'b0
                       : ((r_state == PED_FLASH) && tick_1hz) ? ~r_flash_dark
                       : r_flash_dark;

    // State, request latches, arbitration memory and registered lamp decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= RED_B;
            r_ped_req    <= 1'b0;
            r_side_req   <= 1'b0;
            r_rr_last    <= 1'b0;
            r_elapsed    <= '0;
            r_flash_dark <= 1'b0;
            r_main_light <= RED;
            r_side_light <= RED;
            r_ped_light  <= DONT_WALK;
        end else begin
            r_state      <= w_next;
            r_flash_dark <= w_next_dark;
            r_main_light <= main_light_of(w_next);
            r_side_light <= side_light_of(w_next);
            r_ped_light  <= ped_light_of(w_next, w_next_dark);

            if (w_enter && (w_next == PED_WALK))
                r_ped_req <= 1'b0;
            else if (ped_btn && (r_state != PED_WALK) && (r_state != PED_FLASH))
                r_ped_req <= 1'b1;

            if (w_enter && (w_next == SIDE_G))
                r_side_req <= 1'b0;
            else if (side_sensor && (r_state != SIDE_G) && (r_state != SIDE_Y))
                r_side_req <= 1'b1;

            if ((r_state == RED_A) && w_enter) begin
                if (w_next == SIDE_G)        r_rr_last <= 1'b0;
                else if (w_next == PED_WALK) r_rr_last <= 1'b1;
            end

            if (w_enter)
                r_elapsed <= '0;
            else if ((r_state == MAIN_G) && tick_1hz && (r_elapsed < CNT_W'(T_MAIN_MIN)))
                r_elapsed <= r_elapsed + CNT_W'(1);
        end
    end

`ifdef PED_COUNTDOWN_EN
    logic [CNT_W-1:0] r_ped_remain;

    // Seconds left in the crossing, live only through walk and flash
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ped_remain <= '0;
        else if (w_enter && (w_next == PED_WALK))
            r_ped_remain <= CNT_W'(T_WALK + T_FLASH);
        else if ((w_next != PED_WALK) && (w_next != PED_FLASH))
            r_ped_remain <= '0;
        else if (tick_1hz)
            r_ped_remain <= r_ped_remain - CNT_W'(1);
    end

    assign ped_remain = r_ped_remain;
`endif

    assign main_light = r_main_light;
    assign side_light = r_side_light;
    assign ped_light  = r_ped_light;
    assign ped_wait   = r_ped_req;
    assign phase      = r_state;

endmodule

// File: doc/intersection_phase_ctrl.md
Name: intersection_phase_ctrl

Overview:
- Two-road intersection controller: main road, side road, and one pedestrian crossing.
- Latches side-road vehicle requests and pedestrian button requests, then arbitrates between them round-robin.
- Sequences the main, side and pedestrian lights through timed phases.
- Runs on the 74.25 MHz system clock; all timing advances only on the 1 Hz enable pulse from the existing one-Hz generator.

Parameters:
- T_MAIN_MIN, 10: minimum main-green seconds before a request can be served.
- T_YELLOW, 3: yellow seconds, both roads.
- T_ALL_RED, 1: all-red clearance seconds.
- T_SIDE_G, 8: side-green seconds.
- T_WALK, 7: steady WALK seconds.
- T_FLASH, 4: flashing DONT_WALK seconds.
- CNT_W, 5: timer width; every T_* value must be ≥1 and < 2^CNT_W.

Ports:
- clk  in  1  system clock, 74.25 MHz.
- rst  in  1  asynchronous reset, active-high.
- tick_1hz  in  1  one-clk-wide pulse, once per second.
- ped_btn  in  1  pedestrian button, already synchronized and debounced; level.
- side_sensor  in  1  side-road vehicle detect, synchronized; level.
- main_light  out  3  {R,Y,G}, one-hot.
- side_light  out  3  {R,Y,G}, one-hot.
- ped_light  out  2  {walk, dont_walk}.
- ped_wait  out  1  pedestrian request pending (drives the "WAIT" lamp).
- phase  out  3  current state encoding, for debug.

Behaviour:
- Encodings:
  - Lights: RED=100, YELLOW=010, GREEN=001.
  - Pedestrian: WALK=10, DONT_WALK=01, DARK=00.
- Outputs are a Moore decode of the state register only. There is no latency beyond the state flop, and no combinational path from any input to any output.
- States and outputs (main / side / ped):
  - MAIN_G: G / R / DONT_WALK.
  - MAIN_Y: Y / R / DONT_WALK.
  - RED_A: R / R / DONT_WALK.
  - SIDE_G: R / G / DONT_WALK.
  - SIDE_Y: R / Y / DONT_WALK.
  - PED_WALK: R / R / WALK.
  - PED_FLASH: R / R / alternates DONT_WALK and DARK, toggling on each tick; first value DONT_WALK.
  - RED_B: R / R / DONT_WALK.
- Timer:
  - On state entry, load the down-counter with T-1.
  - Decrement on each tick_1hz.
  - Leave the state on the tick where the counter equals 0. A state with T=1 exits on the first tick after entry.
  - Ticks are ignored except for decrementing and exit decisions.
- MAIN_G:
  - Keep a saturating elapsed-seconds counter, cleared on entry and capped at T_MAIN_MIN.
  - On a tick, go to MAIN_Y if elapsed ≥ T_MAIN_MIN and (ped_req or side_req).
  - Otherwise remain in MAIN_G indefinitely.
- Fixed transitions:
  - MAIN_Y → RED_A after T_YELLOW.
  - SIDE_G → SIDE_Y after T_SIDE_G.
  - SIDE_Y → RED_B after T_YELLOW.
  - PED_WALK → PED_FLASH after T_WALK.
  - PED_FLASH → RED_B after T_FLASH.
  - RED_B → MAIN_G after T_ALL_RED.
- RED_A exit (after T_ALL_RED) is the grant point:
  - Only side_req pending → SIDE_G.
  - Only ped_req pending → PED_WALK.
  - Both pending → serve the requester not served last. rr_last: 0 = side served last, 1 = ped served last. Reset value 0, so pedestrian wins the first tie.
  - Neither pending → MAIN_G. This cannot normally occur; it is a safe fallback.
  - Update rr_last on every grant.
- Request latches:
  - ped_req is set by ped_btn=1 and cleared on entry to PED_WALK. A press while in PED_WALK or PED_FLASH is ignored.
  - side_req is set by side_sensor=1 and cleared on entry to SIDE_G. A detect while in SIDE_G or SIDE_Y is ignored.
  - When set and clear occur in the same cycle, clear wins.
  - ped_wait = ped_req.
- Reset (asynchronous, any time, including mid-phase):
  - State RED_B, timer = T_ALL_RED-1.
  - ped_req=0, side_req=0, rr_last=0, elapsed=0, flash phase = DONT_WALK.
  - Outputs: main_light=100, side_light=100, ped_light=01, ped_wait=0.
- Safety invariant: main_light and side_light are never both non-RED, and WALK is never shown with either road non-RED.

Optional Feature:
- Macro: PED_COUNTDOWN_EN.
- Defined:
  - Adds output port ped_remain[CNT_W-1:0] = seconds remaining in the crossing, counting down through PED_WALK and PED_FLASH.
  - Loaded with T_WALK+T_FLASH on PED_WALK entry and decremented per tick.
  - Reads 0 in all other states and at reset.
  - T_WALK+T_FLASH must fit in CNT_W bits.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package traffic_pkg holds:
  - the state enum (3-bit);
  - light constants RED/YELLOW/GREEN;
  - pedestrian constants WALK/DONT_WALK/DARK.
- One sub-module, phase_timer: a loadable CNT_W down-counter with tick enable and a done flag (counter==0 && tick). It is instantiated once and reloaded on every state entry.

Test Plan:
- Reset release with no requests, 30 ticks → RED_B for 1 tick, then MAIN_G held; main=001, side=100, ped=01 throughout.
- side_sensor pulsed at tick 3 → MAIN_Y at tick 10, RED_A at 13, SIDE_G at 14, SIDE_Y at 22, RED_B at 25, MAIN_G at 26; side_req clears on SIDE_G entry.
- ped_btn pulsed 1 clk at tick 12 → ped_wait=1 immediately, MAIN_Y on the next tick, WALK for 7 ticks, flash 01/00 for 4 ticks, then RED_B; ped_wait falls on PED_WALK entry. A press during WALK leaves ped_wait=0.
- Both requests pending at the RED_A grant, from reset → PED_WALK first; side still pending, so after return to MAIN_G and 10 s → SIDE_G. The next tie goes to side.
- rst asserted mid-SIDE_G, asynchronously between edges → lights go to 100/100/01 immediately and latches clear; after release the sequence restarts from RED_B.
- With PED_COUNTDOWN_EN: ped_remain reads 11 on PED_WALK entry, 0 on RED_B entry, and 0 in every other state.
